// File: rtl/crg_seq.sv
// Clock-enable divider and staged reset sequencer with reset-cause latch.
// Optional watchdog is compiled in with CRG_WDT_EN.
`timescale 1ns/1ps
module crg_seq #(
  parameter int NUM_RST     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int DIV         = 4,
  parameter int DEBOUNCE    = 4,
  parameter int WDT_CYCLES  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_rst_n,
  input  logic               sw_rst_req,
`ifdef CRG_WDT_EN
  input  logic               wdt_kick,
`endif
  output logic [NUM_RST-1:0] rst_n,
  output logic               clk_en,
  output logic               ready,
  output logic [1:0]         rst_cause
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int VW = $clog2(DIV + 1);
  localparam int BW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] RELEASE = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  logic [1:0]         state_reg;
  logic [HW-1:0]      hold_cnt_reg;
  logic [GW-1:0]      gap_cnt_reg;
  logic [NUM_RST-1:0] rst_n_reg;
  logic               ready_reg;
  logic [1:0]         cause_reg;
  logic [VW-1:0]      div_cnt_reg;
  logic               clk_en_reg;
  logic               sync1_reg;
  logic               sync2_reg;
  logic [BW-1:0]      deb_cnt_reg;
  logic               req_ext;
  logic               req_wdt;
  logic               any_src;
  logic [NUM_RST:0]   rst_n_ext;
  logic [NUM_RST-1:0] rst_n_shift;

  // Free-running divider; only the power-on reset touches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg <= '0;
      clk_en_reg  <= 1'b0;
    end else begin
      clk_en_reg  <= (div_cnt_reg == VW'(DIV - 1));
      div_cnt_reg <= (div_cnt_reg == VW'(DIV - 1)) ? '0 : div_cnt_reg + 1'b1;
    end
  end

  // Synchroniser idles high (button released) so reset does not look like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      deb_cnt_reg <= '0;
    end else begin
      sync1_reg <= ext_rst_n;
      sync2_reg <= sync1_reg;
      if (sync2_reg)
        deb_cnt_reg <= '0;
      else if (deb_cnt_reg != BW'(DEBOUNCE))
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
    end
  end

  // Request asserts on the sample that brings the low run up to DEBOUNCE.
  assign req_ext = !sync2_reg && (({1'b0, deb_cnt_reg} + 1'b1) >= (BW + 1)'(DEBOUNCE));

`ifdef CRG_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES);
  logic [WW-1:0] wdt_cnt_reg;

  assign req_wdt = (state_reg == RUN) && (wdt_cnt_reg == WW'(WDT_CYCLES - 1)) && !wdt_kick;

  always_ff @(posedge clk) begin
    if (rst || state_reg != RUN || wdt_kick || any_src)
      wdt_cnt_reg <= '0;
    else
      wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
  end
`else
  // No watchdog: the timeout source can never fire.
  assign req_wdt = (WDT_CYCLES < 0);
`endif

  assign any_src     = req_ext | sw_rst_req | req_wdt;
  assign rst_n_ext   = {rst_n_reg, 1'b1};
  assign rst_n_shift = rst_n_ext[NUM_RST-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= HOLD;
      hold_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      rst_n_reg    <= '0;
      ready_reg    <= 1'b0;
      cause_reg    <= 2'b00;
    end else if (any_src) begin
      state_reg    <= HOLD;
      hold_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      rst_n_reg    <= '0;
      ready_reg    <= 1'b0;
      cause_reg    <= req_ext ? 2'b01 : (sw_rst_req ? 2'b10 : 2'b11);
    end else begin
      ready_reg <= (state_reg == RUN);
      case (state_reg)
        HOLD: begin
          if (hold_cnt_reg == HW'(HOLD_CYCLES - 1)) begin
            hold_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            rst_n_reg    <= NUM_RST'(1);
            state_reg    <= (NUM_RST == 1) ? RUN : RELEASE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        RELEASE: begin
          // Shifting a one in from the bottom releases bits strictly in order.
          if (gap_cnt_reg == GW'(STAGE_GAP - 1)) begin
            gap_cnt_reg <= '0;
            rst_n_reg   <= rst_n_shift;
            if (&rst_n_shift)
              state_reg <= RUN;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        RUN: rst_n_reg <= '1;
        default: state_reg <= HOLD;
      endcase
    end
  end

  assign rst_n     = rst_n_reg;
  assign ready     = ready_reg;
  assign clk_en    = clk_en_reg;
  assign rst_cause = cause_reg;

endmodule
